lt_seq_ctrl: RTL and testbench

Sequencer for the latency tester datapath. It runs a programmable batch of back-to-back latency measurements by driving the tester's active, armed and trigger controls. It collects each run's lat_result/stb_result into min/max/sum statistics and reports batch completion to the CPU status interface. The block sits in the clk27 domain between the CPU control registers and the latency tester instance.

---
 rtl/lt_pkg.sv | 30 +++
 rtl/lt_stat_accum.sv | 67 ++++++
 rtl/lt_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lt_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_pkg.sv
// Shared types and constants for the latency tester sequencer and its statistics block.
package lt_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_ARM,
    S_TRIG,
    S_WAIT,
    S_CAPTURE,
    S_DISARM,
    S_GAP,
    S_DONE
  } lt_state_e;

  localparam int LAT_W = 16;
  localparam int STB_W = 12;
  localparam int SUM_W = 20;
  localparam int TMO_W = 5;

  localparam logic [LAT_W-1:0] LT_LAT_TIMEOUT = 16'hffff;

  // One tester tick (10 us) in clk27 cycles; software uses this to convert results.
  localparam int CLK27_PER_TICK = 270;

  function automatic logic [31:0] lat_to_clk27(input logic [LAT_W-1:0] lat);
    return 32'(lat) * 32'(CLK27_PER_TICK);
  endfunction

endpackage

// File: rtl/lt_stat_accum.sv
// Running min/max/sum/stb_max/timeout statistics over the runs of one batch.
module lt_stat_accum
  import lt_pkg::*;
(
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             upd,
  input  logic [LAT_W-1:0] lat,
  input  logic [STB_W-1:0] stb,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [STB_W-1:0] stb_max,
  output logic [TMO_W-1:0] timeout_cnt
);

  logic [LAT_W-1:0] min_q, min_d, max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [STB_W-1:0] stbm_q, stbm_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    sum_d  = sum_q;
    stbm_d = stbm_q;
    tmo_d  = tmo_q;
    if (clear) begin
      min_d  = LT_LAT_TIMEOUT;
      max_d  = '0;
      sum_d  = '0;
      stbm_d = '0;
      tmo_d  = '0;
    end else if (upd) begin
      if (lat < min_q) min_d = lat;
      if (lat > max_q) max_d = lat;
      // At most 16 runs of 16'hffff, so the 20-bit sum cannot wrap.
      sum_d = sum_q + SUM_W'(lat);
      if (stb > stbm_q) stbm_d = stb;
      if (lat == LT_LAT_TIMEOUT) tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      min_q  <= LT_LAT_TIMEOUT;
      max_q  <= '0;
      sum_q  <= '0;
      stbm_q <= '0;
      tmo_q  <= '0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      stbm_q <= stbm_d;
      tmo_q  <= tmo_d;
    end
  end

  assign lat_min     = min_q;
  assign lat_max     = max_q;
  assign lat_sum     = sum_q;
  assign stb_max     = stbm_q;
  assign timeout_cnt = tmo_q;

endmodule

// File: rtl/lt_seq_ctrl.sv
// Batch sequencer for the latency tester: arm/trigger handshake, watchdog, gap timing and status.
module lt_seq_ctrl
  import lt_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2700000,
  parameter int unsigned WD_CYCLES  = 33554432,
  parameter int unsigned TRIG_HOLD  = 4,
  parameter int unsigned SETTLE     = 4
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       num_runs,
  input  logic             lt_finished,
  input  logic [LAT_W-1:0] lat_result,
  input  logic [STB_W-1:0] stb_result,
  output logic             lt_active,
  output logic             lt_armed,
  output logic             lt_trigger,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [3:0]       run_idx,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [STB_W-1:0] stb_max,
  output logic [TMO_W-1:0] timeout_cnt
);

  lt_state_e        state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [3:0]       last_idx_q, last_idx_d;
  logic [3:0]       run_idx_q, run_idx_d;
  logic [LAT_W-1:0] cap_lat_q, cap_lat_d;
  logic [STB_W-1:0] cap_stb_q, cap_stb_d;
  logic             done_q, done_d, aborted_q, aborted_d;
  logic             act_q, act_d, armed_q, armed_d, trig_q, trig_d;
  logic             idle_like, go, stat_upd;

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    run_idx_d  = run_idx_q;
    cap_lat_d  = cap_lat_q;
    cap_stb_d  = cap_stb_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    go         = idle_like && start && !abort;

    if (idle_like) begin
      if (go) begin
        state_d = S_INIT;
        // num_runs==0 wraps to last index 15, i.e. a 16-run batch.
        last_idx_d = num_runs - 4'd1;
        run_idx_d  = '0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
      end
    end else if (abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_INIT: state_d = S_ARM;
        S_ARM: if (cnt_q == SETTLE - 1) state_d = S_TRIG;
        S_TRIG: begin
          if (lt_finished) begin
            state_d   = S_CAPTURE;
            cap_lat_d = lat_result;
            cap_stb_d = stb_result;
          end else if (cnt_q == TRIG_HOLD - 1) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (lt_finished) begin
            state_d   = S_CAPTURE;
            cap_lat_d = lat_result;
            cap_stb_d = stb_result;
          end else if (cnt_q == WD_CYCLES - 1) begin
            state_d   = S_CAPTURE;
            cap_lat_d = LT_LAT_TIMEOUT;
            cap_stb_d = '0;
          end
        end
        S_CAPTURE: state_d = S_DISARM;
        // The tester drops finished only once it is back in idle.
        S_DISARM: if (!lt_finished) state_d = S_GAP;
        S_GAP: begin
          if (cnt_q == GAP_CYCLES - 1) begin
            if (run_idx_q == last_idx_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_ARM;
              run_idx_d = run_idx_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // One timer serves every state; it restarts on each state change.
    if ((state_d != state_q) || (state_d == S_IDLE) || (state_d == S_DONE))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 32'd1;

    act_d    = !((state_d == S_IDLE) || (state_d == S_DONE));
    armed_d  = (state_d == S_ARM) || (state_d == S_TRIG) ||
               (state_d == S_WAIT) || (state_d == S_CAPTURE);
    trig_d   = (state_d == S_TRIG);
    stat_upd = (state_q == S_CAPTURE) && !abort;
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      run_idx_q  <= '0;
      cap_lat_q  <= '0;
      cap_stb_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      act_q      <= 1'b0;
      armed_q    <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      run_idx_q  <= run_idx_d;
      cap_lat_q  <= cap_lat_d;
      cap_stb_q  <= cap_stb_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      act_q      <= act_d;
      armed_q    <= armed_d;
      trig_q     <= trig_d;
    end
  end

  lt_stat_accum u_stat (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .clear       (go),
    .upd         (stat_upd),
    .lat         (cap_lat_q),
    .stb         (cap_stb_q),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_sum     (lat_sum),
    .stb_max     (stb_max),
    .timeout_cnt (timeout_cnt)
  );

  assign lt_active  = act_q;
  assign busy       = act_q;
  assign lt_armed   = armed_q;
  assign lt_trigger = trig_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign run_idx    = run_idx_q;

endmodule

// File: tb/tb_lt_seq_ctrl.sv
// Bench for lt_seq_ctrl: behavioural tester model, table-driven batches, random batches, corner sequences.
module tb_lt_seq_ctrl;
  import lt_pkg::*;

  localparam int GAP = 20;
  localparam int WD  = 1000;
  localparam int TH  = 4;
  localparam int ST  = 4;

  logic        clk27 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  num_runs = '0;
  logic        lt_finished;
  logic [15:0] lat_result;
  logic [11:0] stb_result;
  logic        lt_active, lt_armed, lt_trigger, busy, done, aborted;
  logic [3:0]  run_idx;
  logic [15:0] lat_min, lat_max;
  logic [19:0] lat_sum;
  logic [11:0] stb_max;
  logic [4:0]  timeout_cnt;

  lt_seq_ctrl #(.GAP_CYCLES(GAP), .WD_CYCLES(WD), .TRIG_HOLD(TH), .SETTLE(ST)) dut (
    .clk27(clk27), .reset_n(reset_n), .start(start), .abort(abort), .num_runs(num_runs),
    .lt_finished(lt_finished), .lat_result(lat_result), .stb_result(stb_result),
    .lt_active(lt_active), .lt_armed(lt_armed), .lt_trigger(lt_trigger), .busy(busy),
    .done(done), .aborted(aborted), .run_idx(run_idx), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .stb_max(stb_max), .timeout_cnt(timeout_cnt)
  );

  always #5 clk27 = ~clk27;

  int cyc = 0;
  always @(posedge clk27) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    else n_pass++;
  endtask

  // Tester model: per-run result, response delay and hang flag.
  logic [15:0] t_lat [16];
  logic [11:0] t_stb [16];
  int          t_dly [16];
  bit          t_hang [16];
  int          t_ptr = 0, t_cur = 0, t_cnt = 0, t_hc = 0;
  bit          t_counting = 0, t_trig_prev = 0;
  int          fin_hold = 2;
  int          fin_falls = 0;
  int          fall_cyc = 0;

  initial begin : tester
    lt_finished = 1'b0;
    lat_result  = '0;
    stb_result  = '0;
    forever begin
      @(negedge clk27);
      if (!lt_active) begin
        lt_finished = 1'b0;
        t_counting  = 0;
        t_ptr       = 0;
      end else begin
        if (lt_trigger && !t_trig_prev) begin
          t_cur = t_ptr; t_ptr++; t_counting = 1; t_cnt = 0;
        end
        if (t_counting) begin
          if (!lt_armed) t_counting = 0;
          else if (!t_hang[t_cur] && t_cnt >= t_dly[t_cur]) begin
            lt_finished = 1'b1; lat_result = t_lat[t_cur]; stb_result = t_stb[t_cur];
            t_counting = 0; t_hc = 0;
          end else t_cnt++;
        end
        if (lt_finished && !lt_armed) begin
          t_hc++;
          if (t_hc >= fin_hold) begin
            lt_finished = 1'b0; fin_falls++; fall_cyc = cyc;
          end
        end
      end
      t_trig_prev = lt_trigger;
    end
  end

  typedef struct {
    logic [15:0] mn, mx;
    logic [19:0] sm;
    logic [11:0] sx;
    logic [4:0]  tmo;
  } stats_t;

  function automatic stats_t ref_stats(input int n);
    stats_t s;
    logic [15:0] l;
    logic [11:0] b;
    s.mn = 16'hffff; s.mx = '0; s.sm = '0; s.sx = '0; s.tmo = '0;
    for (int i = 0; i < n; i++) begin
      l = t_hang[i] ? 16'hffff : t_lat[i];
      b = t_hang[i] ? 12'd0 : t_stb[i];
      if (l < s.mn) s.mn = l;
      if (l > s.mx) s.mx = l;
      s.sm = s.sm + 20'(l);
      if (b > s.sx) s.sx = b;
      if (l == 16'hffff) s.tmo = s.tmo + 5'd1;
    end
    return s;
  endfunction

  task automatic chk_stats(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                           input logic [19:0] sm, input logic [11:0] sx, input logic [4:0] tmo,
                           input logic [3:0] idx);
    chk({tag, "_lat_min"}, lat_min, mn);
    chk({tag, "_lat_max"}, lat_max, mx);
    chk({tag, "_lat_sum"}, lat_sum, sm);
    chk({tag, "_stb_max"}, stb_max, sx);
    chk({tag, "_timeout_cnt"}, timeout_cnt, tmo);
    chk({tag, "_run_idx"}, run_idx, idx);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lt_active"}, lt_active, 0);
    chk({tag, "_lt_armed"}, lt_armed, 0);
    chk({tag, "_lt_trigger"}, lt_trigger, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk_stats(tag, 16'hffff, 16'h0, 20'h0, 12'h0, 5'h0, 4'h0);
  endtask

  task automatic run_batch(input logic [3:0] nr, input bit poke);
    int n;
    bit poked;
    @(negedge clk27); num_runs = nr; start = 1'b1;
    @(negedge clk27); start = 1'b0; num_runs = 4'($urandom);
    n = 0; poked = 0;
    while (!done && n < 40000) begin
      @(negedge clk27); n++;
      if (poke && !poked && lt_armed) begin
        start = 1'b1; num_runs = nr + 4'd3; poked = 1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("batch_done", done, 1);
    chk("batch_not_aborted", aborted, 0);
    chk("batch_idle", busy, 0);
  endtask

  typedef struct {
    logic [3:0]  nr;
    logic [15:0] lat0, lat1, lat2;
    logic [11:0] stb;
    logic [2:0]  hang;
    bit          poke;
    logic [15:0] e_min, e_max;
    logic [19:0] e_sum;
    logic [11:0] e_stb;
    logic [4:0]  e_tmo;
    logic [3:0]  e_idx;
  } vec_t;

  vec_t vt [5];
  stats_t rs;
  int n, k, h, r, f0, rise_cyc, nr_i;
  bit prev;

  initial begin
    vt[0] = '{4'd3, 16'd120, 16'd80, 16'd200, 12'd150, 3'b000, 1'b1,
              16'd80, 16'd200, 20'd400, 12'd150, 5'd0, 4'd2};
    vt[1] = '{4'd0, 16'hffff, 16'hffff, 16'hffff, 12'd7, 3'b000, 1'b0,
              16'hffff, 16'hffff, 20'hFFFF0, 12'd7, 5'd16, 4'd15};
    vt[2] = '{4'd2, 16'd0, 16'd50, 16'd50, 12'd9, 3'b001, 1'b0,
              16'd50, 16'hffff, 20'd65585, 12'd9, 5'd1, 4'd1};
    vt[3] = '{4'd1, 16'd0, 16'd0, 16'd0, 12'd0, 3'b000, 1'b0,
              16'd0, 16'd0, 20'd0, 12'd0, 5'd0, 4'd0};
    vt[4] = '{4'd4, 16'd1000, 16'd2000, 16'd65534, 12'd4095, 3'b000, 1'b0,
              16'd1000, 16'd65534, 20'd134068, 12'd4095, 5'd0, 4'd3};

    repeat (3) @(negedge clk27);
    #1 chk_reset("reset");
    @(negedge clk27); reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) begin
        t_lat[i]  = (i == 0) ? vt[v].lat0 : (i == 1) ? vt[v].lat1 : vt[v].lat2;
        t_stb[i]  = vt[v].stb;
        t_hang[i] = vt[v].hang[(i > 2) ? 2 : i];
        t_dly[i]  = (i % 3 == 0) ? 1 : 6 + i;
      end
      run_batch(vt[v].nr, vt[v].poke);
      chk_stats($sformatf("vec%0d", v), vt[v].e_min, vt[v].e_max, vt[v].e_sum,
                vt[v].e_stb, vt[v].e_tmo, vt[v].e_idx);
    end

    for (int b = 0; b < 6; b++) begin
      nr_i = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) begin
        t_lat[i]  = ($urandom_range(0, 5) == 0) ? 16'hffff : 16'($urandom);
        t_stb[i]  = 12'($urandom);
        t_dly[i]  = $urandom_range(0, 20);
        t_hang[i] = ($urandom_range(0, 7) == 0);
      end
      run_batch(4'(nr_i), 1'b0);
      rs = ref_stats(nr_i);
      chk_stats($sformatf("rand%0d", b), rs.mn, rs.mx, rs.sm, rs.sx, rs.tmo, 4'(nr_i - 1));
    end

    // Handshake timing: settle, trigger width, gap held off until finished falls.
    fin_hold = 15;
    for (int i = 0; i < 16; i++) begin
      t_lat[i] = 16'(300 + 100 * i); t_stb[i] = 12'd5; t_dly[i] = 30; t_hang[i] = 0;
    end
    @(negedge clk27); num_runs = 4'd2; start = 1'b1;
    @(negedge clk27); start = 1'b0;
    n = 0; while (!lt_armed && n < 100) begin @(negedge clk27); n++; end
    k = 0; while (!lt_trigger && k < 100) begin @(negedge clk27); k++; end
    chk("settle_cycles", k, ST);
    h = 0; while (lt_trigger && h < 100) begin @(negedge clk27); h++; end
    chk("trig_hold_cycles", h, TH);
    f0 = fin_falls;
    n = 0; while (fin_falls == f0 && n < 500) begin @(negedge clk27); n++; end
    n = 0; while (!lt_armed && n < 500) begin @(negedge clk27); n++; end
    rise_cyc = cyc;
    chk("gap_after_fin_fall", rise_cyc - fall_cyc, GAP + 1);
    n = 0; while (!done && n < 2000) begin @(negedge clk27); n++; end
    chk("hs_done", done, 1);
    chk("hs_lat_sum", lat_sum, 700);
    fin_hold = 2;

    // Abort in WAIT of run 2 of 4.
    t_lat[0] = 16'd111; t_stb[0] = 12'd22; t_dly[0] = 3;
    t_lat[1] = 16'd999; t_stb[1] = 12'd33; t_dly[1] = 300;
    @(negedge clk27); num_runs = 4'd4; start = 1'b1;
    @(negedge clk27); start = 1'b0;
    r = 0; prev = 0; n = 0;
    while (r < 2 && n < 2000) begin
      @(negedge clk27); n++;
      if (lt_trigger && !prev) r++;
      prev = lt_trigger;
    end
    while (lt_trigger && n < 2000) begin @(negedge clk27); n++; end
    repeat (5) @(negedge clk27);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk27); abort = 1'b0;
    chk("abort_lt_active", lt_active, 0);
    chk("abort_lt_armed", lt_armed, 0);
    chk("abort_lt_trigger", lt_trigger, 0);
    chk("abort_busy", busy, 0);
    chk("abort_aborted", aborted, 1);
    chk("abort_done", done, 0);
    chk_stats("abort", 16'd111, 16'd111, 20'd111, 12'd22, 5'd0, 4'd1);

    // abort and start together from IDLE: start is dropped.
    @(negedge clk27); num_runs = 4'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk27); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_aborted", aborted, 1);
    @(negedge clk27);
    chk("abort_start_busy2", busy, 0);

    // Reset pulse mid-GAP.
    t_lat[0] = 16'd500; t_stb[0] = 12'd44; t_dly[0] = 5;
    @(negedge clk27); num_runs = 4'd3; start = 1'b1;
    @(negedge clk27); start = 1'b0;
    f0 = fin_falls;
    n = 0; while (fin_falls == f0 && n < 500) begin @(negedge clk27); n++; end
    repeat (3) @(negedge clk27);
    chk("gap_pre_reset_busy", busy, 1);
    chk("gap_pre_reset_sum", lat_sum, 500);
    reset_n = 1'b0;
    #1 chk_reset("midgap_reset");
    @(negedge clk27); reset_n = 1'b1;
    @(negedge clk27);
    chk("post_reset_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
